// File: rtl/dmem_access_controller_if.sv
// Data-memory request/response bus between the access controller (master)
// and the memory (slave): one valid/ready request channel, one valid-only response.
interface dmem_access_controller_if #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32
);
  logic                   dmem_req_valid;
  logic                   dmem_req_ready;
  logic [ADDR_BITS-1:0]   dmem_req_addr;
  logic                   dmem_req_we;
  logic [DATA_BITS/8-1:0] dmem_req_wstrb;
  logic [DATA_BITS-1:0]   dmem_req_wdata;
  logic                   dmem_resp_valid;
  logic [DATA_BITS-1:0]   dmem_resp_data;

  modport master (
    output dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wstrb, dmem_req_wdata,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_data
  );

  modport slave (
    input  dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wstrb, dmem_req_wdata,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_data
  );
endinterface

// File: rtl/dmem_access_controller.sv
// Sequences stage-2 loads/stores onto the dmem bus and hands load words to stage 3.
// Optional DMEM_MISALIGN_TRAP_EN: traps misaligned half/word ops instead of issuing them.
module dmem_access_controller #(
  parameter int DATA_BITS      = 32,
  parameter int ADDR_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s2_mem_valid,
  input  logic                 s2_mem_we,
  input  logic [2:0]           s2_funct3,
  input  logic [ADDR_BITS-1:0] s2_addr,
  input  logic [DATA_BITS-1:0] s2_wdata,
  output logic                 stall,
  dmem_access_controller_if.master dmem,
  output logic [DATA_BITS-1:0] s3_rdata,
  output logic [2:0]           s3_rdata_sel,
  output logic [1:0]           byte_select,
  output logic                 s3_load_valid,
  output logic                 bus_err
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic                 misalign
`endif
);

  localparam logic [2:0] S3_RDATA_SEL_PASSTHROUGH          = 3'd0;
  localparam logic [2:0] S3_RDATA_SEL_LOW_BYTE             = 3'd1;
  localparam logic [2:0] S3_RDATA_SEL_LOW_BYTE_SIGNED      = 3'd2;
  localparam logic [2:0] S3_RDATA_SEL_LOW_HALF_WORD        = 3'd3;
  localparam logic [2:0] S3_RDATA_SEL_LOW_HALF_WORD_SIGNED = 3'd4;

  localparam int STRB_BITS = DATA_BITS / 8;
  localparam int CNT_BITS  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

  state_t              state;
  logic [CNT_BITS-1:0] timeout_cnt;
  logic                misaligned_op;

  function automatic logic [2:0] load_sel(input logic [2:0] funct3);
    case (funct3)
      3'b000:  load_sel = S3_RDATA_SEL_LOW_BYTE_SIGNED;
      3'b100:  load_sel = S3_RDATA_SEL_LOW_BYTE;
      3'b001:  load_sel = S3_RDATA_SEL_LOW_HALF_WORD_SIGNED;
      3'b101:  load_sel = S3_RDATA_SEL_LOW_HALF_WORD;
      default: load_sel = S3_RDATA_SEL_PASSTHROUGH;
    endcase
  endfunction

  // Upper strobe bits of a half-word at offset 3 fall off the 4-lane word.
  function automatic logic [STRB_BITS-1:0] store_strobe(input logic [2:0] funct3,
                                                        input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   store_strobe = STRB_BITS'(1) << off;
      2'b01:   store_strobe = STRB_BITS'(3) << off;
      default: store_strobe = '1;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    misaligned_op = 1'b0;
    case (s2_funct3[1:0])
      2'b01:   misaligned_op = s2_addr[0];
      2'b10:   misaligned_op = (s2_addr[1:0] != 2'b00);
      default: misaligned_op = 1'b0;
    endcase
  end
`else
  assign misaligned_op = 1'b0;
`endif

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:           stall = s2_mem_valid && !misaligned_op;
      REQ, WAIT_RESP: stall = 1'b1;
      default:        stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      timeout_cnt         <= '0;
      dmem.dmem_req_valid <= 1'b0;
      dmem.dmem_req_addr  <= '0;
      dmem.dmem_req_we    <= 1'b0;
      dmem.dmem_req_wstrb <= '0;
      dmem.dmem_req_wdata <= '0;
      s3_rdata            <= '0;
      s3_rdata_sel        <= S3_RDATA_SEL_PASSTHROUGH;
      byte_select         <= 2'b00;
      s3_load_valid       <= 1'b0;
      bus_err             <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign            <= 1'b0;
`endif
    end else begin
      s3_load_valid <= 1'b0;
      bus_err       <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign      <= (state == IDLE) && s2_mem_valid && misaligned_op;
`endif
      case (state)
        IDLE: begin
          if (s2_mem_valid && !misaligned_op) begin
            dmem.dmem_req_valid <= 1'b1;
            dmem.dmem_req_addr  <= {s2_addr[ADDR_BITS-1:2], 2'b00};
            dmem.dmem_req_we    <= s2_mem_we;
            dmem.dmem_req_wstrb <= s2_mem_we ? store_strobe(s2_funct3, s2_addr[1:0]) : '0;
            dmem.dmem_req_wdata <= s2_wdata << {s2_addr[1:0], 3'b000};
            s3_rdata_sel        <= load_sel(s2_funct3);
            byte_select         <= s2_addr[1:0];
            state               <= REQ;
          end
        end
        // Stores are posted: the handshake alone completes them.
        REQ: begin
          if (dmem.dmem_req_ready) begin
            dmem.dmem_req_valid <= 1'b0;
            timeout_cnt         <= '0;
            state               <= dmem.dmem_req_we ? DONE : WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (dmem.dmem_resp_valid) begin
            s3_rdata      <= dmem.dmem_resp_data;
            s3_load_valid <= 1'b1;
            state         <= DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (32'(timeout_cnt) == TIMEOUT_CYCLES - 1)) begin
            s3_rdata <= '0;
            bus_err  <= 1'b1;
            state    <= DONE;
          end else begin
            timeout_cnt <= timeout_cnt + CNT_BITS'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_controller.sv
// Directed bench for dmem_access_controller (TIMEOUT_CYCLES = 4); covers both
// DMEM_MISALIGN_TRAP_EN builds.
module tb_dmem_access_controller;

  localparam logic [2:0] SEL_PASSTHROUGH          = 3'd0;
  localparam logic [2:0] SEL_LOW_BYTE_SIGNED      = 3'd2;
  localparam logic [2:0] SEL_LOW_HALF_WORD        = 3'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        s2_mem_valid;
  logic        s2_mem_we;
  logic [2:0]  s2_funct3;
  logic [31:0] s2_addr;
  logic [31:0] s2_wdata;
  logic        stall;
  logic [31:0] s3_rdata;
  logic [2:0]  s3_rdata_sel;
  logic [1:0]  byte_select;
  logic        s3_load_valid;
  logic        bus_err;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int total = 0;
  int bad = 0;
  int stall_cycles = 0;
  int load_pulses = 0;
  int req_seen = 0;

  dmem_access_controller_if #(.DATA_BITS(32), .ADDR_BITS(32)) dmem ();

  dmem_access_controller #(
    .DATA_BITS(32),
    .ADDR_BITS(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s2_mem_valid(s2_mem_valid),
    .s2_mem_we(s2_mem_we),
    .s2_funct3(s2_funct3),
    .s2_addr(s2_addr),
    .s2_wdata(s2_wdata),
    .stall(stall),
    .dmem(dmem),
    .s3_rdata(s3_rdata),
    .s3_rdata_sel(s3_rdata_sel),
    .byte_select(byte_select),
    .s3_load_valid(s3_load_valid),
    .bus_err(bus_err)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic we, input logic [2:0] funct3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    s2_mem_valid = valid;
    s2_mem_we    = we;
    s2_funct3    = funct3;
    s2_addr      = addr;
    s2_wdata     = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock: activity is tallied mid-cycle, then outputs settle just after the edge.
  task automatic tick();
    @(negedge clk);
    if (stall) stall_cycles++;
    if (s3_load_valid) load_pulses++;
    if (dmem.dmem_req_valid) req_seen++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  waited;
    bit  seen;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    dmem.dmem_req_ready  = 1'b0;
    dmem.dmem_resp_valid = 1'b0;
    dmem.dmem_resp_data  = 32'h0;
    tick();
    tick();
    checkOutput("rst_stall", stall, 1'b0);
    checkOutput("rst_req_valid", dmem.dmem_req_valid, 1'b0);
    checkOutput("rst_load_valid", s3_load_valid, 1'b0);
    checkOutput("rst_bus_err", bus_err, 1'b0);
    checkOutput("rst_rdata", s3_rdata, 32'h0);
    checkOutput("rst_sel", s3_rdata_sel, SEL_PASSTHROUGH);
    checkOutput("rst_byte_sel", byte_select, 2'd0);
    reset = 1'b0;
    tick();

    $display("[TB] LW 0x100, ready in REQ, response next cycle");
    stall_cycles = 0;
    load_pulses  = 0;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    #1;
    checkOutput("lw_idle_stall", stall, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("lw_req_valid", dmem.dmem_req_valid, 1'b1);
    checkOutput("lw_req_addr", dmem.dmem_req_addr, 32'h100);
    checkOutput("lw_req_we", dmem.dmem_req_we, 1'b0);
    checkOutput("lw_sel", s3_rdata_sel, SEL_PASSTHROUGH);
    checkOutput("lw_byte_sel", byte_select, 2'd0);
    dmem.dmem_req_ready = 1'b1;
    tick();
    dmem.dmem_req_ready = 1'b0;
    checkOutput("lw_wait_req_valid", dmem.dmem_req_valid, 1'b0);
    checkOutput("lw_wait_stall", stall, 1'b1);
    dmem.dmem_resp_valid = 1'b1;
    dmem.dmem_resp_data  = 32'hDEADBEEF;
    tick();
    dmem.dmem_resp_valid = 1'b0;
    checkOutput("lw_load_valid", s3_load_valid, 1'b1);
    checkOutput("lw_rdata", s3_rdata, 32'hDEADBEEF);
    checkOutput("lw_done_stall", stall, 1'b0);
    tick();
    checkOutput("lw_load_valid_drop", s3_load_valid, 1'b0);
    // IDLE, REQ and WAIT_RESP each hold the pipeline for one cycle here.
    checkOutput("lw_stall_cycles", stall_cycles, 3);
    checkOutput("lw_load_pulses", load_pulses, 1);

    $display("[TB] LB 0x103");
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("lb_req_addr", dmem.dmem_req_addr, 32'h100);
    checkOutput("lb_wstrb", dmem.dmem_req_wstrb, 4'b0000);
    checkOutput("lb_sel", s3_rdata_sel, SEL_LOW_BYTE_SIGNED);
    checkOutput("lb_byte_sel", byte_select, 2'd3);
    dmem.dmem_req_ready = 1'b1;
    tick();
    dmem.dmem_req_ready  = 1'b0;
    dmem.dmem_resp_valid = 1'b1;
    dmem.dmem_resp_data  = 32'h11223344;
    tick();
    dmem.dmem_resp_valid = 1'b0;
    checkOutput("lb_load_valid", s3_load_valid, 1'b1);
    checkOutput("lb_rdata", s3_rdata, 32'h11223344);
    tick();

    $display("[TB] SH 0x202 with ready held low for 5 cycles");
    stall_cycles = 0;
    load_pulses  = 0;
    applyStimulus(1'b1, 1'b1, 3'b001, 32'h202, 32'h0000ABCD);
    tick();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'hFFC, 32'h55555555);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("sh_hold%0d_valid", i), dmem.dmem_req_valid, 1'b1);
      checkOutput($sformatf("sh_hold%0d_fields", i),
                  {dmem.dmem_req_addr, dmem.dmem_req_wdata},
                  {32'h200, 32'hABCD0000});
      checkOutput($sformatf("sh_hold%0d_we_strb", i),
                  {dmem.dmem_req_we, dmem.dmem_req_wstrb}, {1'b1, 4'b1100});
      tick();
    end
    dmem.dmem_req_ready = 1'b1;
    tick();
    dmem.dmem_req_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("sh_done_stall", stall, 1'b0);
    checkOutput("sh_done_req_valid", dmem.dmem_req_valid, 1'b0);
    tick();
    checkOutput("sh_stall_cycles", stall_cycles, 7);
    checkOutput("sh_load_pulses", load_pulses, 0);

    $display("[TB] SB 0x001");
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h001, 32'h0000005A);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("sb_req_addr", dmem.dmem_req_addr, 32'h0);
    checkOutput("sb_wstrb", dmem.dmem_req_wstrb, 4'b0010);
    checkOutput("sb_wdata", dmem.dmem_req_wdata, 32'h00005A00);
    dmem.dmem_req_ready = 1'b1;
    tick();
    dmem.dmem_req_ready = 1'b0;
    tick();

    $display("[TB] LW 0x300 with no response");
    stall_cycles = 0;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    dmem.dmem_req_ready = 1'b1;
    tick();
    dmem.dmem_req_ready = 1'b0;
    waited = 0;
    seen   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      waited++;
      if (bus_err) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("to_bus_err_seen", seen, 1'b1);
    checkOutput("to_wait_cycles", waited, 4);
    checkOutput("to_rdata", s3_rdata, 32'h0);
    checkOutput("to_done_stall", stall, 1'b0);
    tick();
    checkOutput("to_bus_err_drop", bus_err, 1'b0);
    checkOutput("to_stall_cycles", stall_cycles, 6);

    $display("[TB] reset while waiting for LHU 0x402, late response");
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h402, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("rmid_sel", s3_rdata_sel, SEL_LOW_HALF_WORD);
    checkOutput("rmid_byte_sel", byte_select, 2'd2);
    dmem.dmem_req_ready = 1'b1;
    tick();
    dmem.dmem_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_pulses = 0;
    dmem.dmem_resp_valid = 1'b1;
    dmem.dmem_resp_data  = 32'hCAFEF00D;
    tick();
    dmem.dmem_resp_valid = 1'b0;
    tick();
    checkOutput("rmid_rdata", s3_rdata, 32'h0);
    checkOutput("rmid_sel_rst", s3_rdata_sel, SEL_PASSTHROUGH);
    checkOutput("rmid_byte_sel_rst", byte_select, 2'd0);
    checkOutput("rmid_stall", stall, 1'b0);
    checkOutput("rmid_req_valid", dmem.dmem_req_valid, 1'b0);
    checkOutput("rmid_req_addr", dmem.dmem_req_addr, 32'h0);
    checkOutput("rmid_bus_err", bus_err, 1'b0);
    checkOutput("rmid_load_pulses", load_pulses, 0);

`ifdef DMEM_MISALIGN_TRAP_EN
    $display("[TB] LW 0x101 trapped as misaligned");
    req_seen    = 0;
    load_pulses = 0;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    #1;
    checkOutput("mis_idle_stall", stall, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("mis_pulse", misalign, 1'b1);
    checkOutput("mis_req_valid", dmem.dmem_req_valid, 1'b0);
    tick();
    tick();
    checkOutput("mis_pulse_drop", misalign, 1'b0);
    checkOutput("mis_req_seen", req_seen, 0);
    checkOutput("mis_load_pulses", load_pulses, 0);
`else
    $display("[TB] LW 0x101 issued unaligned");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("unal_req_valid", dmem.dmem_req_valid, 1'b1);
    checkOutput("unal_req_addr", dmem.dmem_req_addr, 32'h100);
    checkOutput("unal_byte_sel", byte_select, 2'd1);
    dmem.dmem_req_ready = 1'b1;
    tick();
    dmem.dmem_req_ready  = 1'b0;
    dmem.dmem_resp_valid = 1'b1;
    dmem.dmem_resp_data  = 32'h0BADF00D;
    tick();
    dmem.dmem_resp_valid = 1'b0;
    checkOutput("unal_load_valid", s3_load_valid, 1'b1);
    checkOutput("unal_rdata", s3_rdata, 32'h0BADF00D);
    tick();

    $display("[TB] SH 0x203 strobe truncation");
    applyStimulus(1'b1, 1'b1, 3'b001, 32'h203, 32'h00001234);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("sh3_wstrb", dmem.dmem_req_wstrb, 4'b1000);
    checkOutput("sh3_wdata", dmem.dmem_req_wdata, 32'h34000000);
    dmem.dmem_req_ready = 1'b1;
    tick();
    dmem.dmem_req_ready = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
